// File: rtl/stim_check_pkg.sv
// Shared types and defaults for the stimulus/check sequencer.
//   state_e  : sequencer FSM states
//   *_DEF    : default parameter values for the top
//   exp_of   : expected DUT response for a default-width vector
package stim_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned W_DEF      = 8;
    localparam int unsigned INC_DEF    = 1;
    localparam int unsigned SETTLE_DEF = 10;

    // Expected DUT output: vector plus INC, wrapping at the data width.
    function automatic logic [W_DEF-1:0] exp_of(input logic [W_DEF-1:0] v);
        return W_DEF'(v + W_DEF'(INC_DEF));
    endfunction

endpackage

// File: rtl/stim_check_seq_settle_timer.sv
// Settle-window down-counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : reload to SETTLE_CYCLES-1 (has priority over dec)
//   dec       : decrement, stopping at zero
//   expired_c : count is zero (combinational)
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired_c
);

    // Wide enough to hold SETTLE_CYCLES-1; at least one bit for SETTLE_CYCLES==1.
    localparam int unsigned TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(SETTLE_CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expired_c = (cnt == '0);

endmodule

// File: rtl/stim_check_seq.sv
// Stimulus sequencer and checker for an increment DUT.
// Drives an arithmetic sequence of vectors, holds each for SETTLE_CYCLES
// edges, then compares the DUT result against vector+INC.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a run (IDLE only)
//   num_vectors     : vectors in the run (sampled on start)
//   base_value/step : first vector and increment (sampled on start)
//   dut_data_out    : DUT result under check
//   dut_data_in     : registered stimulus to the DUT
//   busy/done/pass  : run status; done is a one-cycle pulse
//   err_count       : saturating mismatch count
//   fail_*          : capture of the first mismatch in the run
module stim_check_seq
    import stim_check_pkg::*;
#(
    parameter int unsigned W             = W_DEF,
    parameter int unsigned INC           = INC_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEF,
    parameter int unsigned NV_W          = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NV_W-1:0]  num_vectors,
    input  logic [W-1:0]     base_value,
    input  logic [W-1:0]     step,
    input  logic [W-1:0]     dut_data_out,
    output logic [W-1:0]     dut_data_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [NV_W-1:0]  fail_index,
    output logic [W-1:0]     fail_data
);

    state_e            state, state_nxt;
    logic [NV_W-1:0]   idx, idx_nxt;
    logic [NV_W-1:0]   num_q, num_nxt;
    logic [W-1:0]      step_q, step_nxt;
    logic [W-1:0]      din_nxt;
    logic [CNT_W-1:0]  err_nxt;
    logic              fv_nxt, pass_nxt;
    logic [NV_W-1:0]   fi_nxt;
    logic [W-1:0]      fd_nxt;
    logic              timer_load_c, timer_dec_c, timer_expired_c;
    logic              mismatch_c;

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load_c),
        .dec       (timer_dec_c),
        .expired_c (timer_expired_c)
    );

    assign mismatch_c = (dut_data_out != W'(dut_data_in + W'(INC)));

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            num_q       <= '0;
            step_q      <= '0;
            dut_data_in <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_valid  <= 1'b0;
            fail_index  <= '0;
            fail_data   <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            num_q       <= num_nxt;
            step_q      <= step_nxt;
            dut_data_in <= din_nxt;
            busy        <= (state_nxt == RUN);
            done        <= (state_nxt == DONE);
            pass        <= pass_nxt;
            err_count   <= err_nxt;
            fail_valid  <= fv_nxt;
            fail_index  <= fi_nxt;
            fail_data   <= fd_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        num_nxt      = num_q;
        step_nxt     = step_q;
        din_nxt      = dut_data_in;
        err_nxt      = err_count;
        fv_nxt       = fail_valid;
        fi_nxt       = fail_index;
        fd_nxt       = fail_data;
        pass_nxt     = pass;
        timer_load_c = 1'b0;
        timer_dec_c  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    err_nxt = '0;
                    fv_nxt  = 1'b0;
                    fi_nxt  = '0;
                    fd_nxt  = '0;
                    if (num_vectors == '0) begin
                        // Empty run: nothing to check, so it trivially passes.
                        pass_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        pass_nxt     = 1'b0;
                        num_nxt      = num_vectors;
                        step_nxt     = step;
                        din_nxt      = base_value;
                        idx_nxt      = '0;
                        timer_load_c = 1'b1;
                        state_nxt    = RUN;
                    end
                end
            end

            RUN: begin
                if (timer_expired_c) begin
                    // Sample edge: check the settled DUT output for this vector.
                    if (mismatch_c) begin
                        if (err_count != '1) begin
                            err_nxt = err_count + CNT_W'(1);
                        end
                        if (!fail_valid) begin
                            fv_nxt = 1'b1;
                            fi_nxt = idx;
                            fd_nxt = dut_data_out;
                        end
                    end
                    if (idx == num_q - NV_W'(1)) begin
                        pass_nxt  = (err_nxt == '0);
                        state_nxt = DONE;
                    end else begin
                        idx_nxt      = idx + NV_W'(1);
                        din_nxt      = W'(dut_data_in + step_q);
                        timer_load_c = 1'b1;
                    end
                end else begin
                    timer_dec_c = 1'b1;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stim_check_seq.sv
// Scoreboard bench for stim_check_seq with a 3-cycle mock increment DUT.
module tb_stim_check_seq;

    localparam int S = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_vectors = '0;
    logic [7:0] base_value = '0;
    logic [7:0] step = '0;
    logic [7:0] dut_data_out;
    logic [7:0] dut_data_in;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_count, fail_index, fail_data;

    logic       start_2 = 1'b0;
    logic [7:0] num_vectors_2 = '0;
    logic [7:0] base_value_2 = '0;
    logic [7:0] step_2 = '0;
    logic [7:0] dut_data_out_2;
    logic [7:0] dut_data_in_2;
    logic       busy_2, done_2, pass_2, fail_valid_2;
    logic [1:0] err_count_2;
    logic [7:0] fail_index_2, fail_data_2;

    stim_check_seq dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .base_value(base_value), .step(step), .dut_data_out(dut_data_out),
        .dut_data_in(dut_data_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid),
        .fail_index(fail_index), .fail_data(fail_data)
    );

    stim_check_seq #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start_2), .num_vectors(num_vectors_2),
        .base_value(base_value_2), .step(step_2), .dut_data_out(dut_data_out_2),
        .dut_data_in(dut_data_in_2), .busy(busy_2), .done(done_2), .pass(pass_2),
        .err_count(err_count_2), .fail_valid(fail_valid_2),
        .fail_index(fail_index_2), .fail_data(fail_data_2)
    );

    // Mock increment DUT, 3-cycle latency, with optional fault on data_in==2.
    logic       fault_en = 1'b0;
    logic [7:0] m1_p0 = '0, m1_p1 = '0, m1_p2 = '0;
    always @(posedge clk) begin
        m1_p0 <= (fault_en && dut_data_in == 8'h02) ? 8'h05 : dut_data_in + 8'h01;
        m1_p1 <= m1_p0;
        m1_p2 <= m1_p1;
    end
    assign dut_data_out = m1_p2;

    // Always-wrong mock: echoes data_in with no increment.
    logic [7:0] m2_p0 = '0, m2_p1 = '0, m2_p2 = '0;
    always @(posedge clk) begin
        m2_p0 <= dut_data_in_2;
        m2_p1 <= m2_p0;
        m2_p2 <= m2_p1;
    end
    assign dut_data_out_2 = m2_p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got='h%0h expected='h%0h (cyc %0d)", nm, got, exp, cyc);
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] din;
        logic [7:0] err;
        logic       fv;
        logic [7:0] fi;
        logic [7:0] fd;
        logic       pass;
    } res_t;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } vec_t;

    res_t res_q[$];
    vec_t vec_q[$];
    res_t mon_r;
    vec_t mon_v;

    // End-of-run monitor: every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (res_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_r = res_q.pop_front();
                chk("done_cycle", cyc, mon_r.cyc);
                chk("busy_at_done", int'(busy), 0);
                chk("final_dut_data_in", int'(dut_data_in), int'(mon_r.din));
                chk("err_count", int'(err_count), int'(mon_r.err));
                chk("fail_valid", int'(fail_valid), int'(mon_r.fv));
                chk("fail_index", int'(fail_index), int'(mon_r.fi));
                chk("fail_data", int'(fail_data), int'(mon_r.fd));
                chk("pass", int'(pass), int'(mon_r.pass));
            end
        end
    end

    // Vector monitor: each new stimulus value while busy must match in value and time.
    logic       busy_d = 1'b0;
    logic [7:0] din_d = '0;
    always @(negedge clk) begin
        if (busy && (!busy_d || dut_data_in != din_d)) begin
            if (vec_q.size() == 0) begin
                chk("unexpected_vector", int'(dut_data_in), -1);
            end else begin
                mon_v = vec_q.pop_front();
                chk("vector_value", int'(dut_data_in), int'(mon_v.v));
                chk("vector_cycle", cyc, mon_v.cyc);
            end
        end
        busy_d <= busy;
        din_d  <= dut_data_in;
    end

    int acc;

    // Issue a start and queue the hand-computed expectations for the run.
    task automatic issue(input logic [7:0] b, input logic [7:0] s, input logic [7:0] n,
                         input logic [7:0] e_din, input logic [7:0] e_err, input logic e_fv,
                         input logic [7:0] e_fi, input logic [7:0] e_fd, input logic e_pass);
        res_t r;
        @(negedge clk);
        acc = cyc + 1;
        for (int i = 0; i < int'(n); i++) begin
            vec_q.push_back('{acc + i * S, 8'(int'(b) + i * int'(s))});
        end
        r.cyc = acc + int'(n) * S;
        r.din = e_din; r.err = e_err; r.fv = e_fv; r.fi = e_fi; r.fd = e_fd; r.pass = e_pass;
        res_q.push_back(r);
        base_value = b; step = s; num_vectors = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && res_q.size() != 0; k++) @(negedge clk);
        chk("run_completes", res_q.size(), 0);
        chk("vectors_drained", vec_q.size(), 0);
        res_q.delete();
        vec_q.delete();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dut_data_in"}, int'(dut_data_in), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_fail_valid"}, int'(fail_valid), 0);
        chk({tag, "_fail_index"}, int'(fail_index), 0);
        chk({tag, "_fail_data"}, int'(fail_data), 0);
    endtask

    initial begin
        int dc;
        bit seen;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal: 0,1,2,3
        issue(8'h00, 8'h01, 8'd4, 8'h03, 8'd0, 1'b0, 8'd0, 8'h00, 1'b1);
        chk("busy_in_run", int'(busy), 1);
        chk("pass_cleared_in_run", int'(pass), 0);
        wait_idle(100);

        // Injected fault on vector 2
        fault_en = 1'b1;
        issue(8'h00, 8'h01, 8'd4, 8'h03, 8'd1, 1'b1, 8'd2, 8'h05, 1'b0);
        wait_idle(100);
        fault_en = 1'b0;

        // Zero vectors: clears error state, stimulus unchanged
        issue(8'h55, 8'h01, 8'd0, 8'h03, 8'd0, 1'b0, 8'd0, 8'h00, 1'b1);
        wait_idle(10);

        // Wrap: FE, FF, 00
        issue(8'hFE, 8'h01, 8'd3, 8'h00, 8'd0, 1'b0, 8'd0, 8'h00, 1'b1);
        wait_idle(100);

        // Start pulsed at edge 5 of a run is ignored
        issue(8'h10, 8'h03, 8'd4, 8'h19, 8'd0, 1'b0, 8'd0, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
        num_vectors = 8'd0; base_value = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", int'(busy), 1);
        wait_idle(100);

        // Reset at edge 15 of a run aborts it
        issue(8'h00, 8'h01, 8'd4, 8'h03, 8'd0, 1'b0, 8'd0, 8'h00, 1'b1);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        res_q.delete();
        vec_q.delete();
        chk_all_zero("midrun_reset");
        dc = done_cnt;
        repeat (50) @(negedge clk);
        chk("no_done_after_reset", done_cnt - dc, 0);

        // Fresh run after reset: 80, C0, 00
        issue(8'h80, 8'h40, 8'd3, 8'h00, 8'd0, 1'b0, 8'd0, 8'h00, 1'b1);
        wait_idle(100);

        // Saturation on the 2-bit counter instance
        @(negedge clk);
        base_value_2 = 8'h20; step_2 = 8'h01; num_vectors_2 = 8'd6; start_2 = 1'b1;
        @(negedge clk);
        start_2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done_2) seen = 1'b1;
        end
        chk("sat_done_seen", int'(seen), 1);
        chk("sat_err_count", int'(err_count_2), 3);
        chk("sat_fail_valid", int'(fail_valid_2), 1);
        chk("sat_fail_index", int'(fail_index_2), 0);
        chk("sat_fail_data", int'(fail_data_2), 'h20);
        chk("sat_pass", int'(pass_2), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
